// File: rtl/edgedet_pkg.sv
// Shared definitions for the multi-channel edge detector: detection mode
// encodings and default parameter values.
package edgedet_pkg;

   typedef enum logic [1:0] {
      MODE_OFF  = 2'b00,
      MODE_RISE = 2'b01,
      MODE_FALL = 2'b10,
      MODE_BOTH = 2'b11
   } mode_e;

   localparam int DEF_WIDTH       = 8;
   localparam int DEF_SYNC_STAGES = 2;
   localparam int DEF_STRETCH     = 1;
   localparam int DEF_CNT_W       = 8;

endpackage

// File: rtl/edgedet_chan.sv
// One detector channel: input synchroniser, previous-level flop, edge
// qualification, pulse stretcher and sticky pending flag.
module edgedet_chan
   import edgedet_pkg::*;
#(
   parameter int SYNC_STAGES = DEF_SYNC_STAGES,
   parameter int STRETCH     = DEF_STRETCH
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       in_i,
   input  logic [1:0] mode_i,
   input  logic       clr_i,
   output logic       detect_o,
   output logic       edge_o,
   output logic       pend_o
);

   localparam int CW = $clog2(STRETCH + 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;
   logic [CW-1:0]          stretch_q, stretch_d;
   logic                   edge_q;
   logic                   pend_q, pend_d;
   logic                   syncOut, rise, fall, detect;

   assign syncOut = sync_q[SYNC_STAGES-1];
   assign rise    = syncOut & ~prev_q;
   assign fall    = ~syncOut & prev_q;

   always_comb begin
      detect = 1'b0;
      unique case (mode_i)
         MODE_RISE: detect = rise;
         MODE_FALL: detect = fall;
         MODE_BOTH: detect = rise | fall;
         default:   detect = 1'b0;
      endcase
   end

   // A detect reloads the full stretch count, so back-to-back detects
   // produce a continuous pulse; a clr losing to a detect keeps pend set.
   always_comb begin
      stretch_d = stretch_q;
      if (detect) begin
         stretch_d = CW'(STRETCH);
      end else if (stretch_q != '0) begin
         stretch_d = stretch_q - CW'(1);
      end
      pend_d = detect | (pend_q & ~clr_i);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync_q    <= '0;
         prev_q    <= 1'b0;
         stretch_q <= '0;
         edge_q    <= 1'b0;
         pend_q    <= 1'b0;
      end else begin
         sync_q[0] <= in_i;
         for (int k = 1; k < SYNC_STAGES; k++) begin
            sync_q[k] <= sync_q[k-1];
         end
         prev_q    <= syncOut;
         stretch_q <= stretch_d;
         edge_q    <= (stretch_d != '0);
         pend_q    <= pend_d;
      end
   end

   assign detect_o = detect;
   assign edge_o   = edge_q;
   assign pend_o   = pend_q;

endmodule

// File: rtl/edgedet_multi.sv
// Multi-channel edge detector top: WIDTH independent channels sharing a
// global mode, plus a saturating count of cycles with any detect.
module edgedet_multi
   import edgedet_pkg::*;
#(
   parameter int WIDTH       = DEF_WIDTH,
   parameter int SYNC_STAGES = DEF_SYNC_STAGES,
   parameter int STRETCH     = DEF_STRETCH,
   parameter int CNT_W       = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] clr,
   input  logic             cnt_clr,
   output logic [WIDTH-1:0] edge_out,
   output logic [WIDTH-1:0] pend,
   output logic             irq,
   output logic [CNT_W-1:0] event_cnt
);

   logic [WIDTH-1:0] detect;
   logic [CNT_W-1:0] eventCnt_q, eventCnt_d;

   for (genvar i = 0; i < WIDTH; i++) begin : gChan
      edgedet_chan #(
         .SYNC_STAGES(SYNC_STAGES),
         .STRETCH    (STRETCH)
      ) uChan (
         .clk_i   (clk),
         .rst_i   (rst),
         .in_i    (in[i]),
         .mode_i  (mode),
         .clr_i   (clr[i]),
         .detect_o(detect[i]),
         .edge_o  (edge_out[i]),
         .pend_o  (pend[i])
      );
   end

   // One increment per detecting cycle regardless of channel count;
   // cnt_clr wins over a simultaneous increment.
   always_comb begin
      eventCnt_d = eventCnt_q;
      if (cnt_clr) begin
         eventCnt_d = '0;
      end else if ((|detect) && (eventCnt_q != '1)) begin
         eventCnt_d = eventCnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         eventCnt_q <= '0;
      end else begin
         eventCnt_q <= eventCnt_d;
      end
   end

   assign event_cnt = eventCnt_q;
   assign irq       = |pend;

endmodule

// File: tb/tb_edgedet_multi.sv
// Scoreboard bench for edgedet_multi (WIDTH=8, SYNC_STAGES=2, STRETCH=3,
// CNT_W=4); expected {edge_out, pend, irq, event_cnt} are queued per cycle.
module tb_edgedet_multi;

   localparam int WIDTH       = 8;
   localparam int SYNC_STAGES = 2;
   localparam int STRETCH     = 3;
   localparam int CNT_W       = 4;

   typedef struct packed {
      logic [7:0] ePulse;
      logic [7:0] ePend;
      logic       eIrq;
      logic [3:0] eCnt;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] inSig;
   logic [1:0] mode;
   logic [7:0] clrSig;
   logic       cntClr;
   logic [7:0] edgeOut;
   logic [7:0] pend;
   logic       irq;
   logic [3:0] eventCnt;

   int   testsRun    = 0;
   int   testsFailed = 0;
   exp_t expQ[$];
   exp_t obs;
   exp_t expV;

   edgedet_multi #(
      .WIDTH      (WIDTH),
      .SYNC_STAGES(SYNC_STAGES),
      .STRETCH    (STRETCH),
      .CNT_W      (CNT_W)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .in       (inSig),
      .mode     (mode),
      .clr      (clrSig),
      .cnt_clr  (cntClr),
      .edge_out (edgeOut),
      .pend     (pend),
      .irq      (irq),
      .event_cnt(eventCnt)
   );

   always #5 clk = ~clk;

   assign obs = {edgeOut, pend, irq, eventCnt};

   function automatic exp_t mk(input logic [7:0] e, input logic [7:0] p, input logic [3:0] c);
      return {e, p, (|p), c};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic doReset(input logic [7:0] inVal, input logic [1:0] m);
      inSig  = inVal;
      mode   = m;
      clrSig = 8'h00;
      cntClr = 1'b0;
      rst    = 1'b1;
      step();
      step();
      rst    = 1'b0;
   endtask

   // Reset with input high, then a rising edge reported at the third edge.
   task automatic test_reset();
      inSig  = 8'h01;
      mode   = 2'b01;
      clrSig = 8'h00;
      cntClr = 1'b0;
      rst    = 1'b1;
      for (int c = 0; c < 8; c++) begin
         if (c == 2) rst = 1'b0;
         if (c >= 4 && c <= 6)  expQ.push_back(mk(8'h01, 8'h01, 4'd1));
         else if (c == 7)       expQ.push_back(mk(8'h00, 8'h01, 4'd1));
         else                   expQ.push_back(mk(8'h00, 8'h00, 4'd0));
         step();
         expV = expQ.pop_front();
         testsRun++;
         if (obs !== expV) begin
            testsFailed++;
            $display("[TB] FAIL test_reset c%0d: got %h want %h (edge,pend,irq,cnt)", c, obs, expV);
         end
      end
   endtask

   task automatic test_falling();
      doReset(8'h00, 2'b10);
      for (int c = 0; c < 16; c++) begin
         if (c == 0)  inSig = 8'h08;
         if (c == 10) inSig = 8'h00;
         if (c >= 12 && c <= 14) expQ.push_back(mk(8'h08, 8'h08, 4'd1));
         else if (c == 15)       expQ.push_back(mk(8'h00, 8'h08, 4'd1));
         else                    expQ.push_back(mk(8'h00, 8'h00, 4'd0));
         step();
         expV = expQ.pop_front();
         testsRun++;
         if (obs !== expV) begin
            testsFailed++;
            $display("[TB] FAIL test_falling c%0d: got %h want %h (edge,pend,irq,cnt)", c, obs, expV);
         end
      end
   endtask

   // Mode off still tracks the input; a later mode change leaves a running pulse alone.
   task automatic test_mode_off();
      doReset(8'h00, 2'b00);
      for (int c = 0; c < 20; c++) begin
         if (c == 0)  inSig = 8'h10;
         if (c == 6)  mode  = 2'b01;
         if (c == 10) inSig = 8'h00;
         if (c == 14) inSig = 8'h10;
         if (c == 17) mode  = 2'b00;
         if (c >= 16 && c <= 18) expQ.push_back(mk(8'h10, 8'h10, 4'd1));
         else if (c == 19)       expQ.push_back(mk(8'h00, 8'h10, 4'd1));
         else                    expQ.push_back(mk(8'h00, 8'h00, 4'd0));
         step();
         expV = expQ.pop_front();
         testsRun++;
         if (obs !== expV) begin
            testsFailed++;
            $display("[TB] FAIL test_mode_off c%0d: got %h want %h (edge,pend,irq,cnt)", c, obs, expV);
         end
      end
   endtask

   task automatic test_back_to_back();
      int s;
      int n;
      doReset(8'h00, 2'b11);
      for (int c = 0; c < 16; c++) begin
         s = c + 1;
         if ((c % 2) == 0 && c <= 10) inSig = inSig ^ 8'h20;
         n = (s < 3) ? 0 : (((s - 3) / 2 + 1) > 6 ? 6 : ((s - 3) / 2 + 1));
         expQ.push_back(mk((s >= 3 && s <= 15) ? 8'h20 : 8'h00,
                           (s >= 3) ? 8'h20 : 8'h00, 4'(n)));
         step();
         expV = expQ.pop_front();
         testsRun++;
         if (obs !== expV) begin
            testsFailed++;
            $display("[TB] FAIL test_back_to_back s%0d: got %h want %h (edge,pend,irq,cnt)", s, obs, expV);
         end
      end
   endtask

   // Twenty detects saturate the 4-bit count, then cnt_clr beats a same-cycle detect.
   task automatic test_saturate();
      doReset(8'h00, 2'b11);
      for (int i = 0; i < 20; i++) begin
         inSig = inSig ^ 8'h01;
         step();
         step();
      end
      for (int i = 0; i < 5; i++) step();
      expQ.push_back(mk(8'h00, 8'h01, 4'd15));
      expV = expQ.pop_front();
      testsRun++;
      if (obs !== expV) begin
         testsFailed++;
         $display("[TB] FAIL test_saturate_top: got %h want %h (edge,pend,irq,cnt)", obs, expV);
      end
      for (int c = 0; c < 4; c++) begin
         if (c == 0) inSig  = inSig ^ 8'h01;
         if (c == 2) cntClr = 1'b1;
         if (c == 3) cntClr = 1'b0;
         if (c >= 2) expQ.push_back(mk(8'h01, 8'h01, 4'd0));
         else        expQ.push_back(mk(8'h00, 8'h01, 4'd15));
         step();
         expV = expQ.pop_front();
         testsRun++;
         if (obs !== expV) begin
            testsFailed++;
            $display("[TB] FAIL test_saturate_clr c%0d: got %h want %h (edge,pend,irq,cnt)", c, obs, expV);
         end
      end
   endtask

   task automatic test_clr();
      doReset(8'h00, 2'b01);
      for (int c = 0; c < 6; c++) begin
         if (c == 0) inSig  = 8'h04;
         if (c == 2) clrSig = 8'h04;
         if (c == 4) clrSig = 8'h00;
         case (c)
            2:       expQ.push_back(mk(8'h04, 8'h04, 4'd1));
            3, 4:    expQ.push_back(mk(8'h04, 8'h00, 4'd1));
            5:       expQ.push_back(mk(8'h00, 8'h00, 4'd1));
            default: expQ.push_back(mk(8'h00, 8'h00, 4'd0));
         endcase
         step();
         expV = expQ.pop_front();
         testsRun++;
         if (obs !== expV) begin
            testsFailed++;
            $display("[TB] FAIL test_clr c%0d: got %h want %h (edge,pend,irq,cnt)", c, obs, expV);
         end
      end
   endtask

   task automatic test_reset_mid();
      doReset(8'h00, 2'b01);
      for (int c = 0; c < 8; c++) begin
         if (c == 0) inSig = 8'h02;
         if (c == 4) rst   = 1'b1;
         if (c == 5) rst   = 1'b0;
         if (c == 2 || c == 3 || c == 7) expQ.push_back(mk(8'h02, 8'h02, 4'd1));
         else                            expQ.push_back(mk(8'h00, 8'h00, 4'd0));
         step();
         expV = expQ.pop_front();
         testsRun++;
         if (obs !== expV) begin
            testsFailed++;
            $display("[TB] FAIL test_reset_mid c%0d: got %h want %h (edge,pend,irq,cnt)", c, obs, expV);
         end
      end
   endtask

   initial begin
      test_reset();
      test_falling();
      test_mode_off();
      test_back_to_back();
      test_saturate();
      test_clr();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

endmodule

// File: doc/edgedet_multi.md
EDGEDET_MULTI -- requirements
Module: edgedet_multi

Interface
REQ-001 The block SHALL take parameter WIDTH, default 8, as the number of independent input channels.
REQ-002 The block SHALL take parameter SYNC_STAGES, default 2, minimum 1, as the number of input synchroniser flops per channel.
REQ-003 The block SHALL take parameter STRETCH, default 1, minimum 1, as the edge_out pulse length in clk cycles.
REQ-004 The block SHALL take parameter CNT_W, default 8, as the event counter width.
REQ-005 The block SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 The block SHALL have port in, input, WIDTH bits: raw (asynchronous) channel inputs.
REQ-008 The block SHALL have port mode, input, 2 bits: 00 off, 01 rising, 10 falling, 11 both (global to all channels).
REQ-009 The block SHALL have port clr, input, WIDTH bits: per-channel pending-flag clear.
REQ-010 The block SHALL have port cnt_clr, input, 1 bit: event counter clear.
REQ-011 The block SHALL have port edge_out, output, WIDTH bits: registered per-channel detect pulse.
REQ-012 The block SHALL have port pend, output, WIDTH bits: sticky per-channel detect flags.
REQ-013 The block SHALL have port irq, output, 1 bit: OR of pend.
REQ-014 The block SHALL have port event_cnt, output, CNT_W bits: saturating count of detect cycles.

Function
REQ-015 Each channel SHALL pass in[i] through SYNC_STAGES flops; a prev flop SHALL hold the last synchroniser output.
REQ-016 The qualified edge SHALL be: rise = sync & ~prev, fall = ~sync & prev; mode selects rise, fall, rise|fall, or none.
REQ-017 Latency SHALL be exact: edge_out[i] rises on the (SYNC_STAGES+1)th rising clk edge that samples the new in[i] level, counting the first sampling edge as 1.
REQ-018 edge_out[i] SHALL stay high for exactly STRETCH cycles after a detect; a new detect during the stretch SHALL reload the full STRETCH count, with no low gap.
REQ-019 pend[i] SHALL set in the same cycle edge_out[i] is loaded by a detect, and SHALL clear on clr[i]; simultaneous detect and clr[i] SHALL leave pend[i]=1.
REQ-020 irq SHALL equal |pend combinationally from the pend registers.
REQ-021 event_cnt SHALL increment by 1 per cycle in which at least one channel detects, regardless of how many channels detect, and SHALL saturate at 2^CNT_W-1.
REQ-022 cnt_clr SHALL zero event_cnt and SHALL take priority over a simultaneous increment.
REQ-023 A mode change SHALL affect detection from the next clk edge; it SHALL NOT alter pend, event_cnt, or an edge_out pulse already in progress.
REQ-024 With mode=00, no detects SHALL occur, but the synchroniser and prev SHALL keep tracking the input.
REQ-025 A pulse narrower than one clk period MAY be missed; no detect SHALL be generated without a level change at the synchroniser output.

Reset
REQ-026 While rst=1 at a clk edge, all synchroniser flops, prev, stretch counters, edge_out, pend and event_cnt SHALL load 0; irq SHALL be 0 as a consequence.
REQ-027 Reset SHALL override clr, cnt_clr and any detect in the same cycle.
REQ-028 After reset release, an input held high SHALL be reported as a rising edge (prev resets to 0) at the latency given in REQ-017.
REQ-029 Reset asserted mid-stretch SHALL end the pulse on that edge.

Structure
REQ-030 Package edgedet_pkg SHALL hold the mode encodings MODE_OFF, MODE_RISE, MODE_FALL and MODE_BOTH, plus the parameter defaults.
REQ-031 A per-channel sub-module edgedet_chan SHALL contain the synchroniser, prev, qualify logic, stretch counter and pend; the top SHALL generate WIDTH instances and own event_cnt.

Verification
All scenarios use WIDTH=8, SYNC_STAGES=2, STRETCH=3, CNT_W=4.
REQ-032 rst=1 for 2 cycles with in=8'h01, then released, mode=01 -> edge_out[0]=1 for 3 cycles starting at the 3rd sampling edge; pend=8'h01; irq=1; event_cnt=1.
REQ-033 mode=10, in[3] goes 1 then 0 after 10 cycles -> only the falling transition gives edge_out[3], for 3 cycles; event_cnt=1.
REQ-034 mode=11, in[5] toggled every 2 cycles -> edge_out[5] held continuously high; event_cnt increments once per toggle.
REQ-035 20 detects on one channel -> event_cnt stops at 15; cnt_clr and a detect in the same cycle -> event_cnt=0.
REQ-036 clr[2] in the same cycle as a channel-2 detect -> pend[2] stays 1; clr[2] alone -> pend[2]=0 and irq=0 if no other flag is set.
REQ-037 rst asserted on the 2nd cycle of a stretch -> edge_out=0 and pend=0 on that edge.
